// File: rtl/nn_drv_pkg.sv
// Shared definitions for the XOR-network driver.
// Contents: FSM state enum, IEEE-754 single-precision constants, the fixed
// weight set, the {A,B} vector table and the expected XOR truth table.
package nn_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } drv_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_HALF = 32'h3F00_0000;

  localparam logic [31:0] FP_POS4 = 32'h4080_0000;
  localparam logic [31:0] FP_NEG4 = 32'hC080_0000;
  localparam logic [31:0] FP_NEG2 = 32'hC000_0000;
  localparam logic [31:0] FP_POS6 = 32'h40C0_0000;
  localparam logic [31:0] FP_NEG6 = 32'hC0C0_0000;

  // {w11,w12,w21,w22,b1,b2,w31,w32,b3}, w11 in the MSBs
  localparam logic [9*32-1:0] NN_WEIGHTS = {
    FP_POS4, FP_POS4, FP_NEG4, FP_NEG4, FP_NEG2,
    FP_POS6, FP_POS4, FP_POS4, FP_NEG6
  };

  // Bit i is the XOR result expected for vector i
  localparam logic [3:0] EXPECTED = 4'b0110;

  // Vector table: idx0 {0,0}, idx1 {0,1}, idx2 {1,0}, idx3 {1,1}.
  // A follows idx[1], B follows idx[0].
  function automatic logic [31:0] vec_val(input logic [1:0] idx, input logic sel_b);
    logic bit_set;
    bit_set = sel_b ? idx[0] : idx[1];
    return bit_set ? FP_ONE : FP_ZERO;
  endfunction

endpackage

// File: rtl/nn_fp_threshold.sv
// Combinational strict greater-than of a float against a positive constant.
// Negative inputs and NaNs always give 0; +Inf gives 1.
// Ports:
//   val_i    in   DATA_WIDTH  float to test
//   above_o  out  1           val_i > THRESH
module nn_fp_threshold
  import nn_drv_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 24,
  parameter logic [EXP_WIDTH+MANT_WIDTH-1:0] THRESH = (EXP_WIDTH+MANT_WIDTH)'(FP_HALF)
) (
  input  logic [EXP_WIDTH+MANT_WIDTH-1:0] val_i,
  output logic                            above_o
);

  localparam int DW = EXP_WIDTH + MANT_WIDTH;

  logic                  sign;
  logic [EXP_WIDTH-1:0]  exp_f;
  logic [MANT_WIDTH-2:0] frac;
  logic                  is_nan;

  assign sign   = val_i[DW-1];
  assign exp_f  = val_i[DW-2 -: EXP_WIDTH];
  assign frac   = val_i[MANT_WIDTH-2:0];
  assign is_nan = (&exp_f) & (|frac);

  // For non-negative floats the magnitude bits order the same as integers,
  // so a plain unsigned compare works once sign and NaN are excluded.
  assign above_o = ~sign & ~is_nan & (val_i[DW-2:0] > THRESH[DW-2:0]);

endmodule

// File: rtl/nn_xor_driver.sv
// Self-check initiator for the XOR network: applies the four {A,B} vectors,
// waits SETTLE_CYCLES per vector, thresholds the result at 0.5 and compares
// against XOR. A start request launches a run; done pulses at the end.
// Optional macro: NN_DRV_EXC_CHECK_EN -- accumulate sampled NN exceptions
// and fail the run on any bit selected by EXC_MASK.
// Ports:
//   clk, rst (async active-high), start
//   nn_result, nn_exceptions          from the NN
//   nn_a, nn_b, nn_weights, nn_round_mode  to the NN
//   busy, res_valid, res_idx, res_data, res_bit, pass_mask, pass, done, exc_accum
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | vector applied, counting down; sample on the cnt==0 edge
// DONE   | one-cycle end-of-run, done=1, pass valid
module nn_xor_driver
  import nn_drv_pkg::*;
#(
  parameter int         EXP_WIDTH     = 8,
  parameter int         MANT_WIDTH    = 24,
  parameter int         SETTLE_CYCLES = 64,
  parameter logic [4:0] EXC_MASK      = 5'b11111
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [EXP_WIDTH+MANT_WIDTH-1:0]       nn_result,
  input  logic [4:0]                            nn_exceptions,
  output logic [EXP_WIDTH+MANT_WIDTH-1:0]       nn_a,
  output logic [EXP_WIDTH+MANT_WIDTH-1:0]       nn_b,
  output logic [9*(EXP_WIDTH+MANT_WIDTH)-1:0]   nn_weights,
  output logic [2:0]                            nn_round_mode,
  output logic                                  busy,
  output logic                                  res_valid,
  output logic [1:0]                            res_idx,
  output logic [EXP_WIDTH+MANT_WIDTH-1:0]       res_data,
  output logic                                  res_bit,
  output logic [3:0]                            pass_mask,
  output logic                                  pass,
  output logic                                  done,
  output logic [4:0]                            exc_accum
);

  localparam int DATA_WIDTH = EXP_WIDTH + MANT_WIDTH;
  localparam int CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  drv_state_e            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  busy_q, busy_d;
  logic                  res_valid_q, res_valid_d;
  logic [1:0]            res_idx_q, res_idx_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_bit_q, res_bit_d;
  logic [3:0]            pass_mask_q, pass_mask_d;
  logic                  pass_q, pass_d;
  logic                  done_q, done_d;
  logic [4:0]            exc_q, exc_d;

  logic                  above;
  logic [4:0]            exc_sample;

  nn_fp_threshold #(
    .EXP_WIDTH (EXP_WIDTH),
    .MANT_WIDTH(MANT_WIDTH),
    .THRESH    (DATA_WIDTH'(FP_HALF))
  ) u_thresh (
    .val_i  (nn_result),
    .above_o(above)
  );

`ifdef NN_DRV_EXC_CHECK_EN
  assign exc_sample = nn_exceptions;
`else
  // Exceptions do not take part in the verdict; exc_accum stays 0.
  logic unused_exc;
  assign unused_exc = ^nn_exceptions;
  assign exc_sample = 5'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    res_bit_d   = res_bit_q;
    pass_mask_d = pass_mask_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    exc_d       = exc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SETTLE;
          idx_d       = 2'd0;
          a_d         = DATA_WIDTH'(vec_val(2'd0, 1'b0));
          b_d         = DATA_WIDTH'(vec_val(2'd0, 1'b1));
          cnt_d       = CNT_RELOAD;
          pass_mask_d = 4'b0;
          exc_d       = 5'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          res_valid_d        = 1'b1;
          res_idx_d          = idx_q;
          res_data_d         = nn_result;
          res_bit_d          = above;
          pass_mask_d[idx_q] = (above == EXPECTED[idx_q]);
          exc_d              = exc_q | exc_sample;
          if (idx_q != 2'd3) begin
            // Next vector goes out on the same edge as the sample
            idx_d = idx_q + 2'd1;
            a_d   = DATA_WIDTH'(vec_val(idx_d, 1'b0));
            b_d   = DATA_WIDTH'(vec_val(idx_d, 1'b1));
            cnt_d = CNT_RELOAD;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (&pass_mask_d) & ~|(exc_d & EXC_MASK);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= 2'd0;
      res_data_q  <= '0;
      res_bit_q   <= 1'b0;
      pass_mask_q <= 4'b0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      exc_q       <= 5'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
      res_bit_q   <= res_bit_d;
      pass_mask_q <= pass_mask_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
      exc_q       <= exc_d;
    end
  end

  assign nn_a          = a_q;
  assign nn_b          = b_q;
  assign nn_weights    = (9*DATA_WIDTH)'(NN_WEIGHTS);
  assign nn_round_mode = 3'b000;
  assign busy          = busy_q;
  assign res_valid     = res_valid_q;
  assign res_idx       = res_idx_q;
  assign res_data      = res_data_q;
  assign res_bit       = res_bit_q;
  assign pass_mask     = pass_mask_q;
  assign pass          = pass_q;
  assign done          = done_q;
  assign exc_accum     = exc_q;

endmodule

// File: tb/tb_nn_xor_driver.sv
module tb_nn_xor_driver;

  localparam int S = 64;
  localparam logic [287:0] EXP_WEIGHTS = {
    32'h40800000, 32'h40800000, 32'hC0800000, 32'hC0800000, 32'hC0000000,
    32'h40C00000, 32'h40800000, 32'h40800000, 32'hC0C00000
  };
  localparam logic [31:0] ONE    = 32'h3F800000;
  localparam logic [31:0] HI_OUT = 32'h3F7AE148;  // ~0.98
  localparam logic [31:0] LO_OUT = 32'h3CA3D70A;  // ~0.02

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  nn_result;
  logic [4:0]   nn_exceptions;
  logic [31:0]  nn_a, nn_b;
  logic [287:0] nn_weights;
  logic [2:0]   nn_round_mode;
  logic         busy, res_valid, res_bit, pass, done;
  logic [1:0]   res_idx;
  logic [31:0]  res_data;
  logic [3:0]   pass_mask;
  logic [4:0]   exc_accum;

  int total = 0;
  int bad   = 0;

  // Stand-in for the NN: the output depends on which vector is applied.
  logic [31:0] stub_val [4];
  logic        exp_bit  [4];
  logic [4:0]  exc_pulse;
  logic [1:0]  vi;

  assign vi        = {nn_a == ONE, nn_b == ONE};
  assign nn_result = stub_val[vi];

  nn_xor_driver #(
    .EXP_WIDTH    (8),
    .MANT_WIDTH   (24),
    .SETTLE_CYCLES(S),
    .EXC_MASK     (5'b11111)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .nn_result    (nn_result),
    .nn_exceptions(nn_exceptions),
    .nn_a         (nn_a),
    .nn_b         (nn_b),
    .nn_weights   (nn_weights),
    .nn_round_mode(nn_round_mode),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_idx      (res_idx),
    .res_data     (res_data),
    .res_bit      (res_bit),
    .pass_mask    (pass_mask),
    .pass         (pass),
    .done         (done),
    .exc_accum    (exc_accum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ideal();
    for (int i = 0; i < 4; i++) begin
      exp_bit[i]  = ((i & 1) ^ (i >> 1)) != 0;
      stub_val[i] = exp_bit[i] ? HI_OUT : LO_OUT;
    end
  endtask

  // Random float of a chosen class; the class alone fixes the expected bit.
  task automatic gen_val(input int cat, output logic [31:0] v, output logic b);
    logic [31:0] r;
    case (cat)
      0: begin v = 32'h0; b = 1'b0; end
      1: begin v = 32'h3F000000; b = 1'b0; end
      2: begin r = $urandom_range(32'h3EFFFFFF, 0); v = {1'b0, r[30:0]}; b = 1'b0; end
      3: begin v = $urandom_range(32'h7F7FFFFF, 32'h3F000001); b = 1'b1; end
      4: begin v = 32'h7F800000; b = 1'b1; end
      5: begin
        r = $urandom_range(32'h007FFFFF, 1);
        v = {r[31], 8'hFF, r[22:0]};
        b = 1'b0;
      end
      default: begin r = $urandom_range(32'h7F800000, 0); v = {1'b1, r[30:0]}; b = 1'b0; end
    endcase
  endtask

  // One full run from IDLE; leaves the bench at the negedge after DONE.
  task automatic run_vectors(input bit poke);
    logic [3:0] m;
    logic       p;
    logic [4:0] ex;
    int         i;
    for (int j = 0; j < 4; j++) m[j] = (exp_bit[j] == (((j & 1) ^ (j >> 1)) != 0));
    p  = &m;
`ifdef NN_DRV_EXC_CHECK_EN
    ex = exc_pulse;
    p  = p & ((exc_pulse & 5'b11111) == 5'b0);
`else
    ex = 5'b0;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 288'(busy), 288'(1'b1));
    check("start_mask_clr", 288'(pass_mask), 288'(4'b0));
    check("start_pass_clr", 288'(pass), 288'(1'b0));
    check("start_exc_clr", 288'(exc_accum), 288'(5'b0));
    for (int k = 1; k <= 4*S+1; k++) begin
      @(negedge clk);
      if (k <= 4*S) check("res_valid", 288'(res_valid), 288'(k % S == 0));
      if (k % S == 0 && k <= 4*S) begin
        i = k / S - 1;
        check("res_idx", 288'(res_idx), 288'(i));
        check("res_bit", 288'(res_bit), 288'(exp_bit[i]));
        check("res_data", 288'(res_data), 288'(stub_val[i]));
        check("mask_bit", 288'(pass_mask[i]), 288'(m[i]));
        if (k < 4*S) check("done_early", 288'(done), 288'(1'b0));
      end
      if (k % S == 1 && k < 4*S) begin
        i = k / S;
        check("nn_a", 288'(nn_a), 288'((i >> 1) != 0 ? ONE : 32'h0));
        check("nn_b", 288'(nn_b), 288'((i & 1) != 0 ? ONE : 32'h0));
        check("busy_run", 288'(busy), 288'(1'b1));
      end
      if (k == 4*S) begin
        check("done", 288'(done), 288'(1'b1));
        check("busy_done", 288'(busy), 288'(1'b0));
        check("pass", 288'(pass), 288'(p));
        check("pass_mask", 288'(pass_mask), 288'(m));
        check("exc_accum", 288'(exc_accum), 288'(ex));
      end
      if (k == 4*S+1) begin
        check("done_once", 288'(done), 288'(1'b0));
        check("valid_low", 288'(res_valid), 288'(1'b0));
        check("busy_idle", 288'(busy), 288'(1'b0));
        check("mask_hold", 288'(pass_mask), 288'(m));
        check("pass_hold", 288'(pass), 288'(p));
      end
      nn_exceptions = (k == 2*S-1) ? exc_pulse : 5'b0;
      if (poke) start = (k == 10 || k == S+5 || k == 4*S);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic        b;
    rst           = 1'b1;
    start         = 1'b0;
    nn_exceptions = 5'b0;
    exc_pulse     = 5'b0;
    set_ideal();

    #3;
    check("rst_busy", 288'(busy), 288'(1'b0));
    check("rst_valid", 288'(res_valid), 288'(1'b0));
    check("rst_idx", 288'(res_idx), 288'(2'b0));
    check("rst_data", 288'(res_data), 288'(32'h0));
    check("rst_bit", 288'(res_bit), 288'(1'b0));
    check("rst_mask", 288'(pass_mask), 288'(4'b0));
    check("rst_pass", 288'(pass), 288'(1'b0));
    check("rst_done", 288'(done), 288'(1'b0));
    check("rst_exc", 288'(exc_accum), 288'(5'b0));
    check("rst_a", 288'(nn_a), 288'(32'h0));
    check("rst_b", 288'(nn_b), 288'(32'h0));
    check("weights", nn_weights, EXP_WEIGHTS);
    check("round_mode", 288'(nn_round_mode), 288'(3'b000));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Ideal NN
    set_ideal();
    run_vectors(1'b0);

    // Exactly 0.5 everywhere
    for (int i = 0; i < 4; i++) begin
      stub_val[i] = 32'h3F000000;
      exp_bit[i]  = 1'b0;
    end
    run_vectors(1'b0);

    // Negative on idx1, NaN on idx2
    set_ideal();
    stub_val[1] = 32'hBF800000; exp_bit[1] = 1'b0;
    stub_val[2] = 32'h7FC00000; exp_bit[2] = 1'b0;
    run_vectors(1'b0);

    // start pulses during SETTLE and DONE are ignored
    set_ideal();
    run_vectors(1'b1);

    // start held high: back-to-back runs
    start = 1'b1;
    @(negedge clk);
    repeat (4*S) @(negedge clk);
    check("held_done", 288'(done), 288'(1'b1));
    @(negedge clk);
    check("held_gap", 288'(busy), 288'(1'b0));
    @(negedge clk);
    check("held_restart", 288'(busy), 288'(1'b1));
    check("held_mask_clr", 288'(pass_mask), 288'(4'b0));
    start = 1'b0;
    repeat (4*S) @(negedge clk);
    check("held_done2", 288'(done), 288'(1'b1));
    check("held_pass2", 288'(pass), 288'(1'b1));
    @(negedge clk);

    // Reset in the middle of vector 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2*S+10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 288'(busy), 288'(1'b0));
    check("arst_valid", 288'(res_valid), 288'(1'b0));
    check("arst_idx", 288'(res_idx), 288'(2'b0));
    check("arst_data", 288'(res_data), 288'(32'h0));
    check("arst_bit", 288'(res_bit), 288'(1'b0));
    check("arst_mask", 288'(pass_mask), 288'(4'b0));
    check("arst_a", 288'(nn_a), 288'(32'h0));
    check("arst_b", 288'(nn_b), 288'(32'h0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("arst_nodone", 288'(done), 288'(1'b0));
    end
    rst = 1'b0;
    @(negedge clk);
    run_vectors(1'b0);

    // Exception seen at the idx1 sample
    exc_pulse = 5'b00001;
    run_vectors(1'b0);
    exc_pulse = 5'b0;

    // Random value classes per vector
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        gen_val($urandom_range(6, 0), v, b);
        stub_val[i] = v;
        exp_bit[i]  = b;
      end
      run_vectors(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
